// File: rtl/pipeline_subtractor_pkg.sv
// Shared helpers for the pipelined subtractor: parameter legality check and slice sizing.
package pipeline_subtractor_pkg;

  // Width must split evenly into a non-zero number of slices.
  function automatic bit cfg_legal(input int dwidth, input int num_stages);
    return (num_stages >= 1) && (dwidth >= 1) && ((dwidth % num_stages) == 0);
  endfunction

  // Slice width; falls back to full width so an illegal config still elaborates far enough to report.
  function automatic int slice_width(input int dwidth, input int num_stages);
    return (num_stages >= 1) ? (dwidth / num_stages) : dwidth;
  endfunction

endpackage

// File: rtl/nadder.sv
// Combinational W-bit adder with carry in/out; used for each subtractor slice.
module nadder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipe_sub_stage.sv
// One pipeline register stage: computes its slice of a - b and carries the rest forward.
module pipe_sub_stage #(
  parameter int DWIDTH    = 8,
  parameter int SLICE     = 4,
  parameter int STAGE_IDX = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_diff,
  input  logic [DWIDTH-1:0] i_a,
  input  logic [DWIDTH-1:0] i_b,
  input  logic              i_carry,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_diff,
  output logic [DWIDTH-1:0] o_a,
  output logic [DWIDTH-1:0] o_b,
  output logic              o_carry
);

  localparam int LO = STAGE_IDX * SLICE;

  logic [SLICE-1:0]  w_b_inv;
  logic [SLICE-1:0]  w_sum;
  logic              w_cout;
  logic [DWIDTH-1:0] w_diff_next;

  logic              r_valid;
  logic [DWIDTH-1:0] r_diff;
  logic [DWIDTH-1:0] r_a;
  logic [DWIDTH-1:0] r_b;
  logic              r_carry;

  // a - b on this slice as a + ~b + carry_in
  assign w_b_inv = ~i_b[LO +: SLICE];

  nadder #(.W(SLICE)) u_nadder (
    .a    (i_a[LO +: SLICE]),
    .b    (w_b_inv),
    .cin  (i_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Merge this slice's result into the partial difference from earlier stages.
  always_comb begin
    w_diff_next             = i_diff;
    w_diff_next[LO +: SLICE] = w_sum;
  end

  // Stage register; holds everything while the pipeline is stalled.
  // Carry resets to 1 so the derived borrow output reads 0 out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b1;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_diff  <= w_diff_next;
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= w_cout;
    end
  end

  assign o_valid = r_valid;
  assign o_diff  = r_diff;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_carry = r_carry;

endmodule

// File: rtl/pipeline_subtractor_top.sv
// Pipelined subtractor: Diff = in1 - in2, Borrow = (in1 < in2), one slice per cycle, with backpressure.
module pipeline_subtractor_top
  import pipeline_subtractor_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              ivalid,
  input  logic              oready,
  output logic [DWIDTH-1:0] Diff,
  output logic              Borrow,
  output logic              ovalid,
  output logic              busy
);

  localparam int SLICE = slice_width(DWIDTH, NUM_STAGES);

  if (!cfg_legal(DWIDTH, NUM_STAGES)) begin : g_cfg_error
    $error("pipeline_subtractor_top: DWIDTH must be a multiple of NUM_STAGES and NUM_STAGES >= 1");
  end

  // Element k is the input of stage k; element NUM_STAGES is the output of the last stage.
  logic              w_valid [0:NUM_STAGES];
  logic [DWIDTH-1:0] w_diff  [0:NUM_STAGES];
  logic [DWIDTH-1:0] w_a     [0:NUM_STAGES];
  logic [DWIDTH-1:0] w_b     [0:NUM_STAGES];
  logic              w_carry [0:NUM_STAGES];
  logic              w_stall;

  // Stage 0 takes operands straight from the ports; carry in of 1 completes the two's complement.
  assign w_valid[0] = ivalid;
  assign w_diff[0]  = '0;
  assign w_a[0]     = in1;
  assign w_b[0]     = in2;
  assign w_carry[0] = 1'b1;

  // A held result at the output freezes the whole pipeline.
  assign w_stall = w_valid[NUM_STAGES] & ~oready;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    pipe_sub_stage #(
      .DWIDTH    (DWIDTH),
      .SLICE     (SLICE),
      .STAGE_IDX (gi)
    ) u_stage (
      .clk     (clk),
      .rstn    (rstn),
      .i_en    (~w_stall),
      .i_valid (w_valid[gi]),
      .i_diff  (w_diff[gi]),
      .i_a     (w_a[gi]),
      .i_b     (w_b[gi]),
      .i_carry (w_carry[gi]),
      .o_valid (w_valid[gi+1]),
      .o_diff  (w_diff[gi+1]),
      .o_a     (w_a[gi+1]),
      .o_b     (w_b[gi+1]),
      .o_carry (w_carry[gi+1])
    );
  end

  assign Diff   = w_diff[NUM_STAGES];
  assign Borrow = ~w_carry[NUM_STAGES];
  assign ovalid = w_valid[NUM_STAGES];
  assign busy   = w_stall;

endmodule
